// File: rtl/spi_pkg.sv
// SPI shared definitions: FSM state encoding and SPI mode constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   spi_state_t  frame engine states IDLE/SETUP/SHIFT/HOLD/FINISH
//   SPI_CPOL     sclk idle level (mode 0)
//   SPI_CPHA     sample on leading edge (mode 0)
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_HOLD   = 3'd3,
    ST_FINISH = 3'd4
  } spi_state_t;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_clk_div.sv
// Enable-gated tick generator: one-cycle tick every CLK_DIV enabled cycles.
// Latency: first tick CLK_DIV cycles after en rises; counter clears when en is low.
// Backpressure: none; free-running while enabled.
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous reset, active-low
//   en    in   count enable; low holds the counter at zero
//   tick  out  high on the last cycle of each CLK_DIV-cycle period
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/spi_master_shifter.sv
// SPI mode-0 master frame engine: parallel word in, serial frame out, received word back.
// Latency: done visible CLK_DIV*(2*DATA_W+2) cycles after the edge that accepts start.
// Backpressure: start is only sampled in IDLE; requests while a frame is active are dropped.
//
// Ports:
//   clk, rst        system clock / async active-low reset
//   start, tx_data  frame request and word to send (latched on acceptance)
//   busy            high from acceptance through the done cycle
//   done, rx_data   one-cycle completion pulse and received word (held until next done)
//   cs_n, sclk      chip select (active-low) and SPI clock (idle low), registered
//   mosi, miso      serial data out (registered) and in
module spi_master_shifter
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              cs_n,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W);

  spi_state_t state, nxt;

  logic              tick;
  logic              div_en;
  logic              accept;
  logic              rise;
  logic              fall;
  logic              last_bit;
  logic [DATA_W-2:0] tx_rest;   // bits still to be driven after the MSB
  logic [DATA_W-1:0] rx_sh;
  logic [BW-1:0]     bitcnt;

  // The divider runs for the whole timed part of the frame so that setup,
  // every sclk half-period and the cs_n hold all last exactly CLK_DIV cycles.
  assign div_en   = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD);
  assign last_bit = (bitcnt == LAST_BIT);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (div_en),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt    = state;
    accept = 1'b0;
    rise   = 1'b0;
    fall   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept = 1'b1;
          nxt    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (!sclk) begin
            rise = 1'b1;
          end else begin
            fall = 1'b1;
            // bitcnt already counted this bit on its rising edge
            if (last_bit) begin
              nxt = ST_HOLD;
            end
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          nxt = ST_FINISH;
        end
      end
      ST_FINISH: begin
        nxt = ST_IDLE;
      end
      default: begin
        nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_rest <= '0;
      rx_sh   <= '0;
      bitcnt  <= '0;
      rx_data <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      cs_n    <= 1'b1;
      sclk    <= SPI_CPOL;
      mosi    <= 1'b0;
    end else begin
      done <= 1'b0;

      if (accept) begin
        tx_rest <= tx_data[DATA_W-2:0];
        rx_sh   <= '0;
        bitcnt  <= '0;
        busy    <= 1'b1;
        cs_n    <= 1'b0;
        sclk    <= SPI_CPOL;
        mosi    <= tx_data[DATA_W-1];
      end

      if (rise) begin
        sclk   <= 1'b1;
        rx_sh  <= {rx_sh[DATA_W-2:0], miso};
        bitcnt <= bitcnt + BW'(1);
      end

      if (fall) begin
        sclk <= 1'b0;
        if (!last_bit) begin
          mosi    <= tx_rest[DATA_W-2];
          tx_rest <= tx_rest << 1;
        end
      end

      // Result and done are presented together for the single FINISH cycle.
      if ((state == ST_HOLD) && tick) begin
        done    <= 1'b1;
        rx_data <= rx_sh;
      end

      // Leaving FINISH releases the bus; a start held high is accepted on the
      // following IDLE cycle, so cs_n is high for exactly one cycle between frames.
      if (state == ST_FINISH) begin
        busy <= 1'b0;
        cs_n <= 1'b1;
        mosi <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_shifter.sv
module tb_spi_master_shifter;

  logic        clk;
  logic        rst;

  logic        start_a, busy_a, done_a, cs_a, sclk_a, mosi_a, miso_a;
  logic [7:0]  txd_a, rxd_a;
  logic        start_b, busy_b, done_b, cs_b, sclk_b, mosi_b, miso_b;
  logic [15:0] txd_b, rxd_b;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   sel    = 0;     // 0: DATA_W=8/CLK_DIV=4 instance, 1: DATA_W=16/CLK_DIV=2 instance
  bit   loop   = 1'b1;  // miso looped back from mosi
  logic miso_src = 1'b0;

  assign miso_a = loop ? mosi_a : miso_src;
  assign miso_b = loop ? mosi_b : miso_src;

  spi_master_shifter #(.DATA_W(8), .CLK_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .tx_data(txd_a), .busy(busy_a),
    .done(done_a), .rx_data(rxd_a), .cs_n(cs_a), .sclk(sclk_a), .mosi(mosi_a), .miso(miso_a)
  );

  spi_master_shifter #(.DATA_W(16), .CLK_DIV(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .tx_data(txd_b), .busy(busy_b),
    .done(done_b), .rx_data(rxd_b), .cs_n(cs_b), .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b)
  );

  logic        o_sclk, o_cs, o_busy, o_done, o_mosi;
  logic [15:0] o_rx;
  assign o_sclk = sel ? sclk_b : sclk_a;
  assign o_cs   = sel ? cs_b   : cs_a;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_done = sel ? done_b : done_a;
  assign o_mosi = sel ? mosi_b : mosi_a;
  assign o_rx   = sel ? rxd_b  : {8'h00, rxd_a};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h want %0h", tag, name, act, exp);
    end
  endtask

  task automatic set_start(input logic v, input logic [15:0] tx);
    if (sel == 0) begin
      start_a = v;
      txd_a   = tx[7:0];
    end else begin
      start_b = v;
      txd_b   = tx;
    end
  endtask

  // Model: a frame sends tx MSB first (one bit per sclk rise), returns the
  // bits seen on miso at the rises, and completes CLK_DIV*(2*W+2) cycles
  // after acceptance with exactly one done pulse. rw supplies miso MSB first.
  task automatic run_frame(input string tag, input int w, input int cd,
                           input logic [15:0] tx, input logic [15:0] rw, input bit lp,
                           input bit poke, input logic [15:0] exp_rx);
    int          cyc, rises, dones, done_cyc, nbit, lat;
    logic        prev_sclk;
    logic [15:0] mosi_word, mask;
    lat      = cd * (2 * w + 2);
    mask     = 16'hFFFF >> (16 - w);
    loop     = lp;
    nbit     = w - 1;
    miso_src = rw[nbit];
    @(negedge clk);
    set_start(1'b1, tx);
    @(negedge clk);
    set_start(1'b0, tx);
    check(tag, "cs_n_after_start", {31'd0, o_cs}, 32'd0);
    check(tag, "busy_after_start", {31'd0, o_busy}, 32'd1);
    check(tag, "mosi_first_bit", {31'd0, o_mosi}, {31'd0, tx[w-1]});
    cyc = 0; rises = 0; dones = 0; done_cyc = -1; mosi_word = '0; prev_sclk = o_sclk;
    while (cyc < lat + 6) begin
      if (o_done) begin
        dones++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          check(tag, "rx_at_done", {16'd0, o_rx}, {16'd0, exp_rx & mask});
        end
      end
      if (o_sclk && !prev_sclk) begin
        rises++;
        mosi_word = {mosi_word[14:0], o_mosi};
      end
      if (!o_sclk && prev_sclk && nbit > 0) begin
        nbit--;
        miso_src = rw[nbit];
      end
      prev_sclk = o_sclk;
      if (poke) begin
        // a start mid-SHIFT and one in the done cycle must both be dropped
        if (cyc == 20 || cyc == lat) set_start(1'b1, ~tx);
        else set_start(1'b0, ~tx);
      end
      @(negedge clk);
      cyc++;
    end
    set_start(1'b0, tx);
    check(tag, "sclk_rises", rises, w);
    check(tag, "mosi_bits", {16'd0, mosi_word & mask}, {16'd0, tx & mask});
    check(tag, "done_cycle", done_cyc, lat);
    check(tag, "done_count", dones, 1);
    check(tag, "rx_held", {16'd0, o_rx}, {16'd0, exp_rx & mask});
    check(tag, "idle_cs_n", {31'd0, o_cs}, 32'd1);
    check(tag, "idle_busy", {31'd0, o_busy}, 32'd0);
    check(tag, "idle_sclk", {31'd0, o_sclk}, 32'd0);
  endtask

  task automatic wait_done(input string tag, input int budget, output int cyc);
    cyc = 0;
    while (!o_done && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (!o_done) check(tag, "done_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [15:0] tx;
    logic [15:0] rw;
    bit          lp;
    bit          poke;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int          c, gap, dseen;
    logic [15:0] tx, rw;
    bit          lp;

    tbl[0] = '{tx: 16'h00A5, rw: 16'h0000, lp: 1'b1, poke: 1'b0, exp: 16'h00A5};
    tbl[1] = '{tx: 16'h0000, rw: 16'h00FF, lp: 1'b0, poke: 1'b0, exp: 16'h00FF};
    tbl[2] = '{tx: 16'h005A, rw: 16'h003C, lp: 1'b0, poke: 1'b1, exp: 16'h003C};
    tbl[3] = '{tx: 16'h0081, rw: 16'h0000, lp: 1'b1, poke: 1'b0, exp: 16'h0081};
    tbl[4] = '{tx: 16'h00FF, rw: 16'h0001, lp: 1'b0, poke: 1'b0, exp: 16'h0001};

    rst = 1'b0; start_a = 1'b0; txd_a = '0; start_b = 1'b0; txd_b = '0;
    repeat (3) @(negedge clk);
    check("reset", "cs_n", {31'd0, cs_a}, 32'd1);
    check("reset", "sclk", {31'd0, sclk_a}, 32'd0);
    check("reset", "mosi", {31'd0, mosi_a}, 32'd0);
    check("reset", "busy", {31'd0, busy_a}, 32'd0);
    check("reset", "done", {31'd0, done_a}, 32'd0);
    check("reset", "rx_data", {24'd0, rxd_a}, 32'd0);
    check("reset", "cs_n_b", {31'd0, cs_b}, 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    sel = 0;
    for (int i = 0; i < 5; i++)
      run_frame($sformatf("tbl%0d", i), 8, 4, tbl[i].tx, tbl[i].rw, tbl[i].lp,
                tbl[i].poke, tbl[i].exp);

    // Back-to-back frames with start held high; tx_data changes after acceptance.
    loop = 1'b1;
    @(negedge clk);
    set_start(1'b1, 16'h003C);
    @(negedge clk);
    set_start(1'b1, 16'h00C3);
    wait_done("b2b1", 200, c);
    check("b2b1", "done_cycle", c, 72);
    check("b2b1", "rx", {16'd0, o_rx}, 32'h3C);
    gap = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_cs) gap++;
      else break;
    end
    check("b2b", "cs_n_gap", gap, 1);
    set_start(1'b0, 16'h00C3);
    wait_done("b2b2", 200, c);
    check("b2b2", "done_cycle", c, 72);
    check("b2b2", "rx", {16'd0, o_rx}, 32'hC3);
    repeat (3) @(negedge clk);

    // Randomised frames on the 8-bit instance.
    for (int i = 0; i < 8; i++) begin
      tx = 16'($urandom_range(0, 255));
      rw = 16'($urandom_range(0, 255));
      lp = 1'($urandom_range(0, 1));
      run_frame($sformatf("rnd8_%0d", i), 8, 4, tx, rw, lp, 1'b0, lp ? tx : rw);
    end

    // Reset in the middle of SHIFT aborts the frame without a done.
    loop = 1'b1;
    @(negedge clk);
    set_start(1'b1, 16'h00F0);
    @(negedge clk);
    set_start(1'b0, 16'h00F0);
    repeat (30) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst", "cs_n", {31'd0, cs_a}, 32'd1);
    check("midrst", "sclk", {31'd0, sclk_a}, 32'd0);
    check("midrst", "busy", {31'd0, busy_a}, 32'd0);
    check("midrst", "rx_data", {24'd0, rxd_a}, 32'd0);
    dseen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done_a) dseen++;
    end
    rst = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done_a) dseen++;
    end
    check("midrst", "no_done", dseen, 0);
    check("midrst", "stays_idle", {31'd0, cs_a}, 32'd1);

    // Wide, fast instance.
    sel = 1;
    run_frame("w16_loop", 16, 2, 16'hA55A, 16'h0000, 1'b1, 1'b0, 16'hA55A);
    for (int i = 0; i < 3; i++) begin
      tx = 16'($urandom_range(0, 65535));
      rw = 16'($urandom_range(0, 65535));
      lp = 1'($urandom_range(0, 1));
      run_frame($sformatf("rnd16_%0d", i), 16, 2, tx, rw, lp, 1'b0, lp ? tx : rw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
